// File: rtl/aes_cipher_iter.sv
// -----------------------------------------------------------------------------
// aes_cipher_iter
//
// Iterative AES encryption core: one AES round per clock, driven by the
// expanded key schedule (Words) of a KeyExpansion block. The same RTL covers
// AES-128/192/256 through NK (4, 6 or 8); the round count is NR = NK + 6.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   encrypt in_data; only looked at while idle
//   in_data   in   [0:127] plaintext, bit 0 = MSB, byte n = bits [8n:8n+7],
//                  column-major AES state order
//   Words     in   [0:4*(NR+1)*32-1] expanded key, word i = bits [32i:32i+31];
//                  must stay stable from the accepting edge until done
//   out_data  out  [0:127] ciphertext, held until the next done or reset
//   busy      out  high while a block is in flight
//   done      out  one-cycle pulse, out_data updated in that cycle
//
// Timing: start sampled at edge k -> done and valid out_data in the cycle
// after edge k+NR. A new start is accepted in the done cycle.
// -----------------------------------------------------------------------------
module aes_cipher_iter #(
    parameter int NK = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [0:127]              in_data,
    input  logic [0:(4*(NK+7)*32)-1]  Words,
    output logic [0:127]              out_data,
    output logic                      busy,
    output logic                      done
);

    localparam int         NR         = NK + 6;
    localparam logic [3:0] LAST_ROUND = 4'(NR);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } fsm_t;

    // Standard AES forward S-box
    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // ------------------------------------------------------------------
    // Round helper functions
    // ------------------------------------------------------------------

    // Multiply by x in GF(2^8) modulo 0x11B, kept to 8 bits
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes: 16 parallel S-box lookups
    function automatic logic [0:127] sub_bytes(input logic [0:127] s);
        logic [0:127] o;
        o = 128'h0;
        for (int n = 0; n < 16; n++) begin
            o[8*n +: 8] = SBOX[s[8*n +: 8]];
        end
        return o;
    endfunction

    // ShiftRows: row r rotates left by r; byte 4c+r takes byte 4((c+r)%4)+r
    function automatic logic [0:127] shift_rows(input logic [0:127] s);
        logic [0:127] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
            end
        end
        return o;
    endfunction

    // MixColumns on one 4-byte column (row 0 in the top byte)
    function automatic logic [0:31] mix_column(input logic [0:31] col);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        a0 = col[0:7];
        a1 = col[8:15];
        a2 = col[16:23];
        a3 = col[24:31];
        // 2*a ^ 3*b ^ c ^ d with 3*b expanded as xtime(b) ^ b
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // MixColumns over all four columns
    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [0:127] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            o[32*c +: 32] = mix_column(s[32*c +: 32]);
        end
        return o;
    endfunction

    // ------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------
    fsm_t         r_fsm;
    logic [0:127] r_state;
    logic [3:0]   r_round;
    logic [0:127] r_out;
    logic         r_busy;
    logic         r_done;

    fsm_t         w_fsm_nxt;
    logic [0:127] w_state_nxt;
    logic [3:0]   w_round_nxt;
    logic [0:127] w_out_nxt;
    logic         w_busy_nxt;
    logic         w_done_nxt;

    logic [0:127] w_key0;
    logic [0:127] w_round_key;
    logic [0:127] w_sr;
    logic [0:127] w_mid_round;
    logic [0:127] w_last_round;

    // Round r uses words 4r..4r+3, i.e. the 128-bit slice starting at r*128
    assign w_key0       = Words[0:127];
    assign w_round_key  = Words[{r_round, 7'b0000000} +: 128];
    assign w_sr         = shift_rows(sub_bytes(r_state));
    assign w_mid_round  = mix_columns(w_sr) ^ w_round_key;
    assign w_last_round = w_sr ^ w_round_key;

    // Next-state and output decode for the IDLE/RUN controller
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        w_out_nxt   = r_out;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                if (start) begin
                    // Initial AddRoundKey folded into the accepting edge
                    w_state_nxt = in_data ^ w_key0;
                    w_round_nxt = 4'd1;
                    w_busy_nxt  = 1'b1;
                    w_fsm_nxt   = S_RUN;
                end else begin
                    w_busy_nxt  = 1'b0;
                end
            end
            S_RUN: begin
                if (r_round == LAST_ROUND) begin
                    // Final round skips MixColumns and lands in out_data
                    w_out_nxt   = w_last_round;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_round_nxt = 4'd0;
                    w_fsm_nxt   = S_IDLE;
                end else begin
                    w_state_nxt = w_mid_round;
                    w_round_nxt = r_round + 4'd1;
                    w_busy_nxt  = 1'b1;
                end
            end
            default: begin
                w_fsm_nxt   = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_round_nxt = 4'd0;
            end
        endcase
    end

    // State, round counter and output registers; reset drops any in-flight block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= S_IDLE;
            r_state <= 128'h0;
            r_round <= 4'd0;
            r_out   <= 128'h0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_state <= w_state_nxt;
            r_round <= w_round_nxt;
            r_out   <= w_out_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign out_data = r_out;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// -----------------------------------------------------------------------------
// tb_aes_cipher_iter
//
// Three instances (NK = 4, 6, 8) share clock and reset. A behavioural AES
// model (S-box derived from the GF(2^8) inverse plus affine map, matrix
// MixColumns, FIPS-197 key expansion) predicts busy/done/out_data for every
// instance; a compare process checks them on every falling edge. Directed
// scenarios add literal checks on known ciphertexts, latency and handshake.
// -----------------------------------------------------------------------------
module tb_aes_cipher_iter;

    localparam int WMAX = 1920;

    localparam logic [0:255] KEY_FIPS = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [0:255] KEY_SEQ  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [0:127] PT_FIPS  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] CT_FIPS  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] PT_C     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] CT_128   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] CT_192   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [0:127] CT_256   = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            start_a [3];
    logic [0:127]    in_a    [3];
    logic [0:WMAX-1] words_a [3];
    logic [0:127]    out_a   [3];
    logic            busy_a  [3];
    logic            done_a  [3];

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    aes_cipher_iter #(.NK(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_a[0]), .in_data(in_a[0]),
        .Words(words_a[0][0:1407]), .out_data(out_a[0]), .busy(busy_a[0]), .done(done_a[0]));
    aes_cipher_iter #(.NK(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .start(start_a[1]), .in_data(in_a[1]),
        .Words(words_a[1][0:1663]), .out_data(out_a[1]), .busy(busy_a[1]), .done(done_a[1]));
    aes_cipher_iter #(.NK(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_a[2]), .in_data(in_a[2]),
        .Words(words_a[2][0:1919]), .out_data(out_a[2]), .busy(busy_a[2]), .done(done_a[2]));

    // ------------------------------------------------------------------
    // Reference AES
    // ------------------------------------------------------------------
    logic [7:0] m_sbox [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_calc(input int v);
        logic [7:0] inv;
        inv = 8'h00;
        for (int u = 1; u < 256; u++) begin
            if (gmul(8'(v), 8'(u)) == 8'h01) inv = 8'(u);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {m_sbox[w[31:24]], m_sbox[w[23:16]], m_sbox[w[15:8]], m_sbox[w[7:0]]};
    endfunction

    function automatic logic [0:WMAX-1] key_expand(input logic [0:255] key, input int nk);
        logic [31:0]     w [60];
        logic [31:0]     tmp;
        logic [7:0]      rcon;
        logic [0:WMAX-1] res;
        rcon = 8'h01;
        res  = '0;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < 4 * (nk + 7); i++) begin
            if (i < nk) begin
                w[i] = key[32*i +: 32];
            end else begin
                tmp = w[i-1];
                if (i % nk == 0) begin
                    tmp  = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
                    rcon = gmul(rcon, 8'h02);
                end else if (nk > 6 && i % nk == 4) begin
                    tmp = sub_word(tmp);
                end
                w[i] = w[i-nk] ^ tmp;
            end
            res[32*i +: 32] = w[i];
        end
        return res;
    endfunction

    function automatic logic [0:127] encrypt(input logic [0:127] pt, input logic [0:WMAX-1] w, input int nk);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [0:127] res;
        coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[8*(4*c+r) +: 8] ^ w[32*c + 8*r +: 8];
        for (int rnd = 1; rnd <= nk + 6; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = m_sbox[s[r][(c+r)%4]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    if (rnd < nk + 6) begin
                        acc = 8'h00;
                        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j-r+4)%4], t[j][c]);
                    end else begin
                        acc = t[r][c];
                    end
                    s[r][c] = acc ^ w[32*(4*rnd+c) + 8*r +: 8];
                end
        end
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[8*(4*c+r) +: 8] = s[r][c];
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Cycle model: countdown of remaining rounds per instance
    // ------------------------------------------------------------------
    int           m_rem  [3];
    logic [0:127] m_res  [3];
    logic [0:127] m_out  [3];
    logic         m_done [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_rem[k]  <= 0;
                m_res[k]  <= '0;
                m_out[k]  <= '0;
                m_done[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                m_done[k] <= 1'b0;
                if (m_rem[k] == 0) begin
                    if (start_a[k]) begin
                        m_res[k] <= encrypt(in_a[k], words_a[k], 4 + 2*k);
                        m_rem[k] <= 10 + 2*k;
                    end
                end else begin
                    m_rem[k] <= m_rem[k] - 1;
                    if (m_rem[k] == 1) begin
                        m_out[k]  <= m_res[k];
                        m_done[k] <= 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Check helpers
    // ------------------------------------------------------------------
    task automatic check128(input string name, input logic [0:127] act, input logic [0:127] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %032h required %032h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %b required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                check_bit($sformatf("busy[%0d]", k), busy_a[k], m_rem[k] != 0);
                check_bit($sformatf("done[%0d]", k), done_a[k], m_done[k]);
                check128($sformatf("out_data[%0d]", k), out_a[k], m_out[k]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus tasks (inputs change 1 time unit after a falling edge)
    // ------------------------------------------------------------------
    task automatic start_block(input int k, input logic [0:127] pt);
        @(negedge clk); #1;
        in_a[k]    = pt;
        start_a[k] = 1'b1;
        @(negedge clk);
        check_bit($sformatf("busy_after_accept[%0d]", k), busy_a[k], 1'b1);
        #1 start_a[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, output int cyc, output int bcnt, output logic got);
        cyc = 0; bcnt = 0; got = 1'b0;
        while (cyc < 40 && !got) begin
            @(negedge clk);
            cyc++;
            if (done_a[k]) got = 1'b1;
            else if (busy_a[k]) bcnt++;
        end
    endtask

    task automatic run_block(input int k, input logic [0:127] pt, input logic [0:127] exp);
        int   cyc;
        int   bcnt;
        logic got;
        start_block(k, pt);
        wait_done(k, cyc, bcnt, got);
        check_bit($sformatf("done_seen[%0d]", k), got, 1'b1);
        check_int($sformatf("latency[%0d]", k), cyc, 10 + 2*k);
        check_int($sformatf("busy_cycles_after_first[%0d]", k), bcnt, 9 + 2*k);
        check_bit($sformatf("busy_low_at_done[%0d]", k), busy_a[k], 1'b0);
        check128($sformatf("ciphertext[%0d]", k), out_a[k], exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int              cyc;
        int              bcnt;
        int              dcnt;
        logic            got;
        logic [0:WMAX-1] wtmp;
        logic [0:127]    exp2;

        for (int v = 0; v < 256; v++) m_sbox[v] = sbox_calc(v);
        for (int k = 0; k < 3; k++) begin
            start_a[k] = 1'b0;
            in_a[k]    = '0;
        end
        words_a[0] = key_expand(KEY_FIPS, 4);
        words_a[1] = key_expand(KEY_SEQ, 6);
        words_a[2] = key_expand(KEY_SEQ, 8);

        // Model pinned to hand-known values
        check_bit("model_sbox_00", m_sbox[8'h00] == 8'h63, 1'b1);
        check_bit("model_sbox_53", m_sbox[8'h53] == 8'hed, 1'b1);
        check_bit("model_gmul", gmul(8'h57, 8'h83) == 8'hc1, 1'b1);
        wtmp = words_a[0];
        check_bit("model_key_w4", wtmp[32*4 +: 32] == 32'ha0fafe17, 1'b1);
        check_bit("model_key_w43", wtmp[32*43 +: 32] == 32'hb6630ca6, 1'b1);
        check128("model_fips", encrypt(PT_FIPS, words_a[0], 4), CT_FIPS);
        check128("model_c128", encrypt(PT_C, key_expand(KEY_SEQ, 4), 4), CT_128);
        check128("model_c192", encrypt(PT_C, words_a[1], 6), CT_192);
        check128("model_c256", encrypt(PT_C, words_a[2], 8), CT_256);

        // Reset state, then 20 idle cycles with start low
        @(negedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            check_bit("reset_busy", busy_a[k], 1'b0);
            check_bit("reset_done", done_a[k], 1'b0);
            check128("reset_out", out_a[k], 128'h0);
        end
        rst_n  = 1'b1;
        chk_en = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check_bit("idle_busy", busy_a[0], 1'b0);
            check128("idle_out", out_a[0], 128'h0);
        end

        // FIPS-197 Appendix B vector
        run_block(0, PT_FIPS, CT_FIPS);

        // start held high; in_data changes after acceptance
        @(negedge clk); #1;
        in_a[0] = PT_FIPS; start_a[0] = 1'b1;
        repeat (3) @(negedge clk);
        #1 in_a[0] = '0;
        wait_done(0, cyc, bcnt, got);
        check_bit("held_done_seen", got, 1'b1);
        check_int("held_latency_rest", cyc, 8);
        check128("held_first_ct", out_a[0], CT_FIPS);
        exp2 = encrypt(128'h0, words_a[0], 4);
        @(negedge clk);
        check_bit("held_second_accept", busy_a[0], 1'b1);
        check_bit("held_done_single", done_a[0], 1'b0);
        #1 start_a[0] = 1'b0;
        wait_done(0, cyc, bcnt, got);
        check_int("held_second_latency", cyc, 10);
        check128("held_second_ct", out_a[0], exp2);

        // start pulse while busy in round 5 must be ignored
        start_block(0, PT_FIPS);
        repeat (4) @(negedge clk);
        #1 in_a[0] = '0; start_a[0] = 1'b1;
        @(negedge clk); #1 start_a[0] = 1'b0;
        wait_done(0, cyc, bcnt, got);
        check_int("busy_start_latency", cyc, 5);
        check128("busy_start_ct", out_a[0], CT_FIPS);
        dcnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (done_a[0] || busy_a[0]) dcnt++;
        end
        check_int("busy_start_no_extra", dcnt, 0);

        // FIPS-197 Appendix C vectors for all three key sizes
        words_a[0] = key_expand(KEY_SEQ, 4);
        run_block(0, PT_C, CT_128);
        run_block(1, PT_C, CT_192);
        run_block(2, PT_C, CT_256);

        // Asynchronous reset during round 6
        start_block(0, PT_C);
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_bit("midreset_busy", busy_a[0], 1'b0);
        check_bit("midreset_done", done_a[0], 1'b0);
        check128("midreset_out", out_a[0], 128'h0);
        check128("midreset_out_nk6", out_a[1], 128'h0);
        @(negedge clk); #1 rst_n = 1'b1;
        dcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_a[0] || busy_a[0]) dcnt++;
        end
        check_int("midreset_no_done", dcnt, 0);
        run_block(0, PT_C, CT_128);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
